// File: rtl/inline_writecontrol.sv
//------------------------------------------------------------------------------
// Module   : inline_writecontrol
// Purpose  : Streams one line of input beats into a mesh of buffers, giving
//            every column its own incrementing address.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inline_writecontrol #(
    parameter int X_MAC        = 4,
    parameter int X_MESH       = 16,
    parameter int ADDR_LEN     = 13,
    parameter int DATA_LEN     = 32,
    parameter int MAX_LINE_LEN = 10,
    parameter int SOON_THRESH  = 7,
    parameter int BUFFER_NUM   = X_MAC * X_MESH,
    parameter int DATAWIDTH    = BUFFER_NUM * DATA_LEN,
    parameter int ADDRWIDTH    = BUFFER_NUM * ADDR_LEN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [ADDR_LEN*X_MAC-1:0] st_addr,
    input  logic [MAX_LINE_LEN-1:0]   linelen,
    input  logic [X_MAC-1:0]          wr_mask,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATAWIDTH-1:0]      in_data,
    output logic [DATAWIDTH-1:0]      dina,
    output logic [ADDRWIDTH-1:0]      addra,
    output logic [BUFFER_NUM-1:0]     wea,
    output logic                      line_done,
    output logic                      idle_soon
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [MAX_LINE_LEN-1:0] c_one_beat    = MAX_LINE_LEN'(1);
    localparam logic [MAX_LINE_LEN-1:0] c_soon_thresh = MAX_LINE_LEN'(SOON_THRESH);

    state_t                      r_state;
    logic [MAX_LINE_LEN-1:0]     r_beats_left;
    logic [ADDR_LEN*X_MAC-1:0]   r_col_addr;
    logic [X_MAC-1:0]            r_mask;

    logic [MAX_LINE_LEN:0]       w_len_plus1;
    logic [MAX_LINE_LEN-1:0]     w_beats_cfg;
    logic [ADDR_LEN*X_MAC-1:0]   w_col_addr_next;
    logic [ADDRWIDTH-1:0]        w_addr_bcast;
    logic [BUFFER_NUM-1:0]       w_wea_bcast;

    // One extra bit keeps (linelen+1) from overflowing before the halving.
    assign w_len_plus1 = {1'b0, linelen} + {{MAX_LINE_LEN{1'b0}}, 1'b1};
    assign w_beats_cfg = MAX_LINE_LEN'(w_len_plus1 >> 1);

    generate
        for (genvar j = 0; j < X_MAC; j++) begin : g_col_next
            assign w_col_addr_next[j*ADDR_LEN +: ADDR_LEN] =
                r_col_addr[j*ADDR_LEN +: ADDR_LEN] + ADDR_LEN'(1);
        end
    endgenerate

    // Every mesh row shares the column address and column enable.
    generate
        for (genvar i = 0; i < X_MESH; i++) begin : g_row
            for (genvar j = 0; j < X_MAC; j++) begin : g_col
                assign w_addr_bcast[(i*X_MAC+j)*ADDR_LEN +: ADDR_LEN] =
                    r_col_addr[j*ADDR_LEN +: ADDR_LEN];
                assign w_wea_bcast[i*X_MAC+j] = r_mask[j];
            end
        end
    endgenerate

    assign cfg_ready = (r_state == IDLE);
    assign in_ready  = (r_state == WRITE);
    assign idle_soon = (r_state == IDLE) ||
                       ((r_state == WRITE) && (r_beats_left <= c_soon_thresh));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_beats_left <= '0;
            r_col_addr   <= '0;
            r_mask       <= '0;
            dina         <= '0;
            addra        <= '0;
            wea          <= '0;
            line_done    <= 1'b0;
        end else begin
            wea       <= '0;
            line_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (cfg_valid) begin
                        r_col_addr   <= st_addr;
                        r_mask       <= wr_mask;
                        r_beats_left <= w_beats_cfg;
                        r_state      <= (w_beats_cfg != '0) ? WRITE : DONE;
                    end
                end
                WRITE: begin
                    if (in_valid) begin
                        dina         <= in_data;
                        addra        <= w_addr_bcast;
                        wea          <= w_wea_bcast;
                        r_col_addr   <= w_col_addr_next;
                        r_beats_left <= r_beats_left - c_one_beat;
                        if (r_beats_left == c_one_beat) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
